// File: rtl/apb4_axil_bridge_if.sv
// Bus interfaces for apb4_axil_bridge.
//   apb4_if : APB4 completer-side bus (paddr/pprot/psel/penable/pwrite/pwdata/pstrb
//             from the requester; pready/prdata/pslverr back to it).
//   axil_if : AXI4-Lite bus (AW, W, B, AR, R channels).
// Modports: master drives the request side, slave drives the response side.

interface apb4_if;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned StrbW = DataW / 8;

  logic [AddrW-1:0] paddr;
  logic [2:0]       pprot;
  logic             psel;
  logic             penable;
  logic             pwrite;
  logic [DataW-1:0] pwdata;
  logic [StrbW-1:0] pstrb;
  logic             pready;
  logic [DataW-1:0] prdata;
  logic             pslverr;

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );
  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

interface axil_if;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned StrbW = DataW / 8;

  logic             awvalid;
  logic             awready;
  logic [AddrW-1:0] awaddr;
  logic [2:0]       awprot;
  logic             wvalid;
  logic             wready;
  logic [DataW-1:0] wdata;
  logic [StrbW-1:0] wstrb;
  logic             bvalid;
  logic             bready;
  logic [1:0]       bresp;
  logic             arvalid;
  logic             arready;
  logic [AddrW-1:0] araddr;
  logic [2:0]       arprot;
  logic             rvalid;
  logic             rready;
  logic [DataW-1:0] rdata;
  logic [1:0]       rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/apb4_axil_bridge.sv
// apb4_axil_bridge: APB4 completer that turns each APB transfer into one
// AXI4-Lite transaction, stretching APB wait states until the AXI response.
// Ports:
//   clk_i   - single clock for both buses
//   rst_i   - synchronous active-high reset
//   apb     - apb4_if.slave, APB requester side
//   mem_axi - axil_if.master, AXI4-Lite initiator side
// Parameter TIMEOUT_CYCLES (1..65535) is used only when APB_AXIL_TIMEOUT_EN
// is defined; the macro adds an AXI response timeout that completes the APB
// transfer with pslverr=1.

module apb4_axil_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic     clk_i,
  input logic     rst_i,
  apb4_if.slave   apb,
  axil_if.master  mem_axi
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RRESP, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  prot_q, prot_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        arvalid_q, arvalid_d;
  logic        bready_q, bready_d;
  logic        rready_q, rready_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic [31:0] prdata_q, prdata_d;
  logic        aw_done_c, w_done_c;
  logic        timeout_c;

  // A channel is done once its valid is low or is being accepted this cycle.
  assign aw_done_c = !awvalid_q || mem_axi.awready;
  assign w_done_c  = !wvalid_q  || mem_axi.wready;

`ifdef APB_AXIL_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        busy_c;

  // Counter is zero in IDLE/DONE, so it is already cleared on entry to WADDR/RADDR.
  assign busy_c    = (state_q == WADDR) || (state_q == WRESP) ||
                     (state_q == RADDR) || (state_q == RRESP);
  assign cnt_d     = busy_c ? cnt_q + 16'd1 : 16'd0;
  assign timeout_c = busy_c && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= 16'd0;
    else       cnt_q <= cnt_d;
  end
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT_CYCLES);
  assign timeout_c      = 1'b0;
`endif

  // Only bit 1 of the AXI response distinguishes error from success.
  logic unused_resp_lsb;
  assign unused_resp_lsb = mem_axi.bresp[0] ^ mem_axi.rresp[0];

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    prot_d    = prot_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    pready_d  = 1'b0;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;

    case (state_q)
      IDLE: begin
        // Only a setup phase starts a transfer; a lingering access phase is ignored.
        if (apb.psel && !apb.penable) begin
          addr_d    = apb.paddr;
          prot_d    = apb.pprot;
          wdata_d   = apb.pwdata;
          strb_d    = apb.pstrb;
          pslverr_d = 1'b0;
          prdata_d  = 32'd0;
          if (apb.pwrite) begin
            state_d   = WADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      WADDR: begin
        if (mem_axi.awready) awvalid_d = 1'b0;
        if (mem_axi.wready)  wvalid_d  = 1'b0;
        if (aw_done_c && w_done_c) state_d = WRESP;
      end
      WRESP: begin
        if (mem_axi.bvalid) begin
          pslverr_d = mem_axi.bresp[1];
          pready_d  = 1'b1;
          state_d   = DONE;
        end
      end
      RADDR: begin
        if (mem_axi.arready) begin
          arvalid_d = 1'b0;
          state_d   = RRESP;
        end
      end
      RRESP: begin
        if (mem_axi.rvalid) begin
          prdata_d  = mem_axi.rdata;
          pslverr_d = mem_axi.rresp[1];
          pready_d  = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        pslverr_d = 1'b0;
        prdata_d  = 32'd0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Timeout abandons the AXI transaction and completes APB with an error.
    if (timeout_c) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      arvalid_d = 1'b0;
      pready_d  = 1'b1;
      pslverr_d = 1'b1;
      prdata_d  = 32'd0;
      state_d   = DONE;
    end

    // Responses are also accepted in IDLE so stray/late ones are drained.
    bready_d = (state_d == IDLE) || (state_d == WRESP);
    rready_d = (state_d == IDLE) || (state_d == RRESP);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= 32'd0;
      prot_q    <= 3'd0;
      wdata_q   <= 32'd0;
      strb_q    <= 4'd0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b1;
      rready_q  <= 1'b1;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      prot_q    <= prot_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign apb.pready      = pready_q;
  assign apb.pslverr     = pslverr_q;
  assign apb.prdata      = prdata_q;
  assign mem_axi.awvalid = awvalid_q;
  assign mem_axi.awaddr  = addr_q;
  assign mem_axi.awprot  = prot_q;
  assign mem_axi.wvalid  = wvalid_q;
  assign mem_axi.wdata   = wdata_q;
  assign mem_axi.wstrb   = strb_q;
  assign mem_axi.bready  = bready_q;
  assign mem_axi.arvalid = arvalid_q;
  assign mem_axi.araddr  = addr_q;
  assign mem_axi.arprot  = prot_q;
  assign mem_axi.rready  = rready_q;

endmodule

// File: tb/tb_apb4_axil_bridge.sv
// Directed self-checking bench for apb4_axil_bridge.

module tb_apb4_axil_bridge;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   errors = 0;
  int   checks = 0;

  apb4_if apb ();
  axil_if mem_axi ();

  apb4_axil_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .apb     (apb),
    .mem_axi (mem_axi)
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic apb_setup(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] p);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr;
    apb.paddr = a; apb.pwdata = d; apb.pstrb = s; apb.pprot = p;
  endtask

  task automatic apb_idle;
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  task automatic test_reset;
    apb_setup(1'b1, 32'h1111_2222, 32'h3333_4444, 4'hF, 3'd7);
    rst_i = 1'b1;
    tick; tick;
    checks++; if (apb.pready !== 1'b0) begin errors++; $display("FAIL reset/pready: got %h expected 0", apb.pready); end
    checks++; if (apb.prdata !== 32'd0) begin errors++; $display("FAIL reset/prdata: got %h expected 0", apb.prdata); end
    checks++; if ({mem_axi.awvalid, mem_axi.wvalid, mem_axi.arvalid} !== 3'b000) begin errors++; $display("FAIL reset/valids: got %b expected 000", {mem_axi.awvalid, mem_axi.wvalid, mem_axi.arvalid}); end
    checks++; if ({mem_axi.bready, mem_axi.rready} !== 2'b11) begin errors++; $display("FAIL reset/readies: got %b expected 11", {mem_axi.bready, mem_axi.rready}); end
    checks++; if ({mem_axi.awaddr, mem_axi.wdata, mem_axi.awprot} !== 67'd0) begin errors++; $display("FAIL reset/addr_data: got %h expected 0", {mem_axi.awaddr, mem_axi.wdata, mem_axi.awprot}); end
    apb_idle();
    rst_i = 1'b0;
    tick;
  endtask

  // Zero-stall write: setup T0, aw/w valid T1, bready T2, pready T3.
  task automatic do_write(input string nm, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] br, input logic exp_err);
    apb_setup(1'b1, a, d, s, 3'b010);
    mem_axi.awready = 1'b1; mem_axi.wready = 1'b1;
    tick; // T1
    checks++; if ({mem_axi.awvalid, mem_axi.wvalid} !== 2'b11) begin errors++; $display("FAIL %s/valid_T1: got %b expected 11", nm, {mem_axi.awvalid, mem_axi.wvalid}); end
    checks++; if (mem_axi.awaddr !== a) begin errors++; $display("FAIL %s/awaddr: got %h expected %h", nm, mem_axi.awaddr, a); end
    checks++; if (mem_axi.wdata !== d) begin errors++; $display("FAIL %s/wdata: got %h expected %h", nm, mem_axi.wdata, d); end
    checks++; if ({mem_axi.wstrb, mem_axi.awprot} !== {s, 3'b010}) begin errors++; $display("FAIL %s/wstrb_prot: got %h expected %h", nm, {mem_axi.wstrb, mem_axi.awprot}, {s, 3'b010}); end
    apb.penable = 1'b1;
    tick; // T2
    checks++; if ({mem_axi.bready, mem_axi.awvalid, mem_axi.wvalid, apb.pready} !== 4'b1000) begin errors++; $display("FAIL %s/T2: got %b expected 1000", nm, {mem_axi.bready, mem_axi.awvalid, mem_axi.wvalid, apb.pready}); end
    mem_axi.awready = 1'b0; mem_axi.wready = 1'b0;
    mem_axi.bvalid = 1'b1; mem_axi.bresp = br;
    tick; // T3
    checks++; if ({apb.pready, apb.pslverr} !== {1'b1, exp_err}) begin errors++; $display("FAIL %s/pready_T3: got %b expected %b", nm, {apb.pready, apb.pslverr}, {1'b1, exp_err}); end
    checks++; if (apb.prdata !== 32'd0) begin errors++; $display("FAIL %s/prdata: got %h expected 0", nm, apb.prdata); end
    mem_axi.bvalid = 1'b0; mem_axi.bresp = 2'b00;
    tick; // T4
    checks++; if (apb.pready !== 1'b0) begin errors++; $display("FAIL %s/pready_T4: got %b expected 0", nm, apb.pready); end
    apb_idle();
  endtask

  // Zero-stall read: setup T0, arvalid T1, rready T2, pready T3.
  task automatic do_read(input string nm, input logic [31:0] a, input logic [31:0] rd,
                         input logic [1:0] rr, input logic exp_err);
    apb_setup(1'b0, a, 32'd0, 4'h0, 3'b001);
    mem_axi.arready = 1'b1;
    tick; // T1
    checks++; if ({mem_axi.arvalid, mem_axi.awvalid} !== 2'b10) begin errors++; $display("FAIL %s/arvalid_T1: got %b expected 10", nm, {mem_axi.arvalid, mem_axi.awvalid}); end
    checks++; if ({mem_axi.araddr, mem_axi.arprot} !== {a, 3'b001}) begin errors++; $display("FAIL %s/araddr: got %h expected %h", nm, {mem_axi.araddr, mem_axi.arprot}, {a, 3'b001}); end
    apb.penable = 1'b1;
    tick; // T2
    checks++; if ({mem_axi.rready, mem_axi.arvalid, apb.pready} !== 3'b100) begin errors++; $display("FAIL %s/T2: got %b expected 100", nm, {mem_axi.rready, mem_axi.arvalid, apb.pready}); end
    mem_axi.arready = 1'b0;
    mem_axi.rvalid = 1'b1; mem_axi.rdata = rd; mem_axi.rresp = rr;
    tick; // T3
    checks++; if ({apb.pready, apb.pslverr} !== {1'b1, exp_err}) begin errors++; $display("FAIL %s/pready_T3: got %b expected %b", nm, {apb.pready, apb.pslverr}, {1'b1, exp_err}); end
    checks++; if (apb.prdata !== rd) begin errors++; $display("FAIL %s/prdata: got %h expected %h", nm, apb.prdata, rd); end
    mem_axi.rvalid = 1'b0; mem_axi.rdata = 32'd0; mem_axi.rresp = 2'b00;
    tick; // T4
    checks++; if ({apb.pready, apb.prdata} !== 33'd0) begin errors++; $display("FAIL %s/T4: got %h expected 0", nm, {apb.pready, apb.prdata}); end
    apb_idle();
  endtask

  task automatic test_write;
    do_write("write", 32'h0300_2004, 32'hA5A5_1234, 4'hF, 2'b00, 1'b0);
    tick;
  endtask

  task automatic test_read;
    do_read("read", 32'h0300_1000, 32'hDEAD_BEEF, 2'b00, 1'b0);
    tick;
  endtask

  // wready at T1, awready only at T4: pready lands at T6.
  task automatic test_split_write;
    logic [5:0] seen_pready;
    apb_setup(1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4'h3, 3'b000);
    mem_axi.wready = 1'b1; mem_axi.awready = 1'b0;
    seen_pready = '0;
    tick; // T1
    checks++; if ({mem_axi.awvalid, mem_axi.wvalid} !== 2'b11) begin errors++; $display("FAIL split/T1: got %b expected 11", {mem_axi.awvalid, mem_axi.wvalid}); end
    apb.penable = 1'b1;
    for (int t = 2; t <= 4; t++) begin
      tick; // T2..T4
      mem_axi.wready = 1'b0;
      seen_pready[t] = apb.pready;
      checks++; if ({mem_axi.awvalid, mem_axi.wvalid} !== 2'b10) begin errors++; $display("FAIL split/T%0d: got %b expected 10", t, {mem_axi.awvalid, mem_axi.wvalid}); end
      if (t == 4) mem_axi.awready = 1'b1;
    end
    tick; // T5
    mem_axi.awready = 1'b0;
    seen_pready[5] = apb.pready;
    checks++; if ({mem_axi.bready, mem_axi.awvalid} !== 2'b10) begin errors++; $display("FAIL split/T5: got %b expected 10", {mem_axi.bready, mem_axi.awvalid}); end
    mem_axi.bvalid = 1'b1; mem_axi.bresp = 2'b01;
    tick; // T6
    checks++; if (seen_pready[5:2] !== 4'b0000) begin errors++; $display("FAIL split/early_pready: got %b expected 0000", seen_pready[5:2]); end
    checks++; if ({apb.pready, apb.pslverr} !== 2'b10) begin errors++; $display("FAIL split/T6: got %b expected 10", {apb.pready, apb.pslverr}); end
    mem_axi.bvalid = 1'b0; mem_axi.bresp = 2'b00;
    tick;
    apb_idle();
    tick;
  endtask

  task automatic test_errors;
    do_write("wr_slverr", 32'h0300_0008, 32'h0000_00FF, 4'h1, 2'b10, 1'b1);
    do_read("rd_decerr", 32'h0300_000C, 32'h1234_5678, 2'b11, 1'b1);
    tick;
  endtask

  // Access phase held past completion must not start a second transfer.
  task automatic test_held_access;
    apb_setup(1'b1, 32'h0000_0100, 32'h1, 4'hF, 3'b000);
    mem_axi.awready = 1'b1; mem_axi.wready = 1'b1;
    tick; apb.penable = 1'b1;
    tick; mem_axi.bvalid = 1'b1;
    tick; mem_axi.bvalid = 1'b0; // T3: pready
    for (int t = 4; t <= 6; t++) begin
      tick;
      checks++; if ({mem_axi.awvalid, mem_axi.wvalid, mem_axi.arvalid, apb.pready} !== 4'b0000) begin errors++; $display("FAIL held/T%0d: got %b expected 0000", t, {mem_axi.awvalid, mem_axi.wvalid, mem_axi.arvalid, apb.pready}); end
    end
    mem_axi.awready = 1'b0; mem_axi.wready = 1'b0;
    apb_idle();
    tick;
  endtask

  // do_write leaves the bus at T4; do_read issues its setup in that same cycle.
  task automatic test_back_to_back;
    do_write("b2b_wr", 32'h0000_0200, 32'hCAFE_0001, 4'hC, 2'b00, 1'b0);
    do_read("b2b_rd", 32'h0000_0204, 32'h5555_AAAA, 2'b01, 1'b0);
    tick;
  endtask

  // A stray response in IDLE is drained without touching APB.
  task automatic test_idle_response;
    mem_axi.rvalid = 1'b1; mem_axi.rdata = 32'hFFFF_FFFF; mem_axi.rresp = 2'b10;
    mem_axi.bvalid = 1'b1; mem_axi.bresp = 2'b10;
    checks++; if ({mem_axi.rready, mem_axi.bready} !== 2'b11) begin errors++; $display("FAIL idle_resp/ready: got %b expected 11", {mem_axi.rready, mem_axi.bready}); end
    tick;
    mem_axi.rvalid = 1'b0; mem_axi.bvalid = 1'b0;
    mem_axi.rresp = 2'b00; mem_axi.bresp = 2'b00; mem_axi.rdata = 32'd0;
    tick;
    checks++; if ({apb.pready, apb.pslverr, apb.prdata} !== 34'd0) begin errors++; $display("FAIL idle_resp/apb: got %h expected 0", {apb.pready, apb.pslverr, apb.prdata}); end
  endtask

  task automatic test_reset_mid_write;
    logic seen;
    apb_setup(1'b1, 32'h0300_2008, 32'h7777_8888, 4'hF, 3'b011);
    mem_axi.awready = 1'b1; mem_axi.wready = 1'b1;
    tick; apb.penable = 1'b1; // T1
    tick; // T2: WRESP
    mem_axi.awready = 1'b0; mem_axi.wready = 1'b0;
    checks++; if (mem_axi.bready !== 1'b1) begin errors++; $display("FAIL rst_mid/wresp: got %b expected 1", mem_axi.bready); end
    rst_i = 1'b1;
    tick; // T3: reset applied
    rst_i = 1'b0;
    checks++; if ({mem_axi.awaddr, mem_axi.wdata, mem_axi.wstrb, mem_axi.awprot} !== 71'd0) begin errors++; $display("FAIL rst_mid/addr_data: got %h expected 0", {mem_axi.awaddr, mem_axi.wdata, mem_axi.wstrb, mem_axi.awprot}); end
    checks++; if ({apb.pready, mem_axi.awvalid, mem_axi.wvalid, mem_axi.bready, mem_axi.rready} !== 5'b00011) begin errors++; $display("FAIL rst_mid/ctrl: got %b expected 00011", {apb.pready, mem_axi.awvalid, mem_axi.wvalid, mem_axi.bready, mem_axi.rready}); end
    seen = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick;
      seen |= apb.pready;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid/no_pready: got %b expected 0", seen); end
    apb_idle();
    tick;
    do_write("rst_mid_next", 32'h0300_200C, 32'h1357_9BDF, 4'h6, 2'b00, 1'b0);
    tick;
  endtask

`ifdef APB_AXIL_TIMEOUT_EN
  // arready never comes: timeout completes APB in cycle T9 (8 busy cycles).
  task automatic test_timeout;
    int hit;
    apb_setup(1'b0, 32'h0300_3000, 32'd0, 4'h0, 3'b000);
    mem_axi.arready = 1'b0;
    hit = 0;
    tick; apb.penable = 1'b1;
    for (int t = 2; t <= 30 && hit == 0; t++) begin
      tick;
      if (apb.pready === 1'b1) hit = t;
    end
    checks++; if (hit != 9) begin errors++; $display("FAIL timeout/cycle: got %0d expected 9", hit); end
    checks++; if ({mem_axi.arvalid, apb.pslverr, apb.prdata} !== {2'b01, 32'd0}) begin errors++; $display("FAIL timeout/resp: got %h expected %h", {mem_axi.arvalid, apb.pslverr, apb.prdata}, {2'b01, 32'd0}); end
    tick;
    apb_idle();
    mem_axi.rvalid = 1'b1; mem_axi.rdata = 32'hBEEF_0000;
    tick;
    mem_axi.rvalid = 1'b0; mem_axi.rdata = 32'd0;
    tick;
    checks++; if ({apb.pready, apb.prdata, mem_axi.rready} !== {33'd0, 1'b1}) begin errors++; $display("FAIL timeout/late_r: got %h expected 1", {apb.pready, apb.prdata, mem_axi.rready}); end
  endtask
`endif

  initial begin
    apb.paddr = '0; apb.pprot = '0; apb.psel = 1'b0; apb.penable = 1'b0;
    apb.pwrite = 1'b0; apb.pwdata = '0; apb.pstrb = '0;
    mem_axi.awready = 1'b0; mem_axi.wready = 1'b0; mem_axi.bvalid = 1'b0;
    mem_axi.bresp = 2'b00; mem_axi.arready = 1'b0; mem_axi.rvalid = 1'b0;
    mem_axi.rdata = '0; mem_axi.rresp = 2'b00;
    test_reset();
    test_write();
    test_read();
    test_split_write();
    test_errors();
    test_held_access();
    test_back_to_back();
    test_idle_response();
    test_reset_mid_write();
`ifdef APB_AXIL_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute guard so a wedged run still terminates with a summary.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
